// File: rtl/ras_ckpt_ctrl.sv
// ras_ckpt_ctrl: return-address-stack checkpoint and recovery controller.
// Each in-flight branch takes one checkpoint of {sp, RAS[sp-2], RAS[sp-1]}
// at dispatch. Checkpoints retire in order at commit. A mispredict flush
// replays the saved pair back into the RAS over two stalled cycles, then
// reloads the stack pointer.
module ras_ckpt_ctrl #(
  parameter int RAS_ADDRESS = 3,
  parameter int XLEN        = 32,
  parameter int CKPT_DEPTH  = 4,
  parameter int TAG_W       = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic [RAS_ADDRESS-1:0] sp_snap,
  input  logic [2*XLEN-1:0]      ras_snap,
  input  logic                   commit_valid,
  input  logic                   flush_valid,
  input  logic [TAG_W-1:0]       flush_tag,
  output logic                   flush_ready,
  output logic                   ras_wr_en,
  output logic [RAS_ADDRESS-1:0] ras_wr_idx,
  output logic [XLEN-1:0]        ras_wr_data,
  output logic                   ras_sp_load,
  output logic [RAS_ADDRESS-1:0] ras_sp_value,
  output logic                   ras_stall,
  output logic                   restore_done,
  output logic [TAG_W:0]         count
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESTORE_LO = 2'd1,
    ST_RESTORE_HI = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  // Checkpoint table; no reset needed, contents are only read for live tags.
  logic [RAS_ADDRESS-1:0] ckpt_sp_q [CKPT_DEPTH];
  logic [XLEN-1:0]        ckpt_hi_q [CKPT_DEPTH];
  logic [XLEN-1:0]        ckpt_lo_q [CKPT_DEPTH];

  // Entry being restored, latched when the flush is accepted.
  logic [RAS_ADDRESS-1:0] rst_sp_q;
  logic [XLEN-1:0]        rst_hi_q;
  logic [XLEN-1:0]        rst_lo_q;

  logic             is_idle;
  logic             commit_fire;
  logic             alloc_fire;
  logic             flush_fire;
  logic [TAG_W-1:0] head_eff;
  logic [TAG_W:0]   count_eff;
  logic [TAG_W-1:0] flush_off;

  assign is_idle     = (state_q == ST_IDLE);
  assign alloc_ready = is_idle && (count_q < (TAG_W+1)'(CKPT_DEPTH));
  assign alloc_tag   = tail_q;
  assign flush_ready = is_idle;
  assign ras_stall   = !is_idle;
  assign count       = count_q;

  // Commit is applied first so that a flush sees the post-commit window.
  assign commit_fire = commit_valid && (count_q != '0);
  assign head_eff    = head_q + TAG_W'(commit_fire);
  assign count_eff   = count_q - (TAG_W+1)'(commit_fire);
  assign flush_off   = flush_tag - head_eff;
  assign flush_fire  = flush_valid && is_idle && ({1'b0, flush_off} < count_eff);
  // A younger alloc in the same cycle as an accepted flush is squashed.
  assign alloc_fire  = alloc_valid && alloc_ready && !flush_fire;

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_eff;
    tail_d  = tail_q;
    count_d = count_eff;
    if (flush_fire) begin
      tail_d  = flush_tag + TAG_W'(1);
      count_d = {1'b0, flush_off} + (TAG_W+1)'(1);
    end else if (alloc_fire) begin
      tail_d  = tail_q + TAG_W'(1);
      count_d = count_eff + (TAG_W+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // One write port per slot, enabled when that slot is the allocation target.
  genvar gi;
  generate
    for (gi = 0; gi < CKPT_DEPTH; gi++) begin : g_slot
      // Capture the snapshot into this slot on an allocation that targets it.
      always_ff @(posedge CLK) begin
        if (alloc_fire && (tail_q == TAG_W'(gi))) begin
          ckpt_sp_q[gi] <= sp_snap;
          ckpt_hi_q[gi] <= ras_snap[2*XLEN-1:XLEN];
          ckpt_lo_q[gi] <= ras_snap[XLEN-1:0];
        end
      end
    end
  endgenerate

  // Registered read of the flushed entry for the restore sequence.
  always_ff @(posedge CLK) begin
    if (flush_fire) begin
      rst_sp_q <= ckpt_sp_q[flush_tag];
      rst_hi_q <= ckpt_hi_q[flush_tag];
      rst_lo_q <= ckpt_lo_q[flush_tag];
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and restore-port decode; writes below index 0 are dropped.
  always_comb begin
    state_d      = state_q;
    ras_wr_en    = 1'b0;
    ras_wr_idx   = '0;
    ras_wr_data  = '0;
    ras_sp_load  = 1'b0;
    ras_sp_value = '0;
    restore_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_fire) state_d = ST_RESTORE_LO;
      end
      ST_RESTORE_LO: begin
        ras_wr_en   = (rst_sp_q != '0);
        ras_wr_idx  = rst_sp_q - RAS_ADDRESS'(1);
        ras_wr_data = rst_lo_q;
        state_d     = ST_RESTORE_HI;
      end
      ST_RESTORE_HI: begin
        ras_wr_en    = (rst_sp_q > RAS_ADDRESS'(1));
        ras_wr_idx   = rst_sp_q - RAS_ADDRESS'(2);
        ras_wr_data  = rst_hi_q;
        ras_sp_load  = 1'b1;
        ras_sp_value = rst_sp_q;
        restore_done = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// tb_ras_ckpt_ctrl: directed self-checking bench for ras_ckpt_ctrl.
module tb_ras_ckpt_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [1:0]  alloc_tag;
  logic [2:0]  sp_snap;
  logic [63:0] ras_snap;
  logic        commit_valid;
  logic        flush_valid;
  logic [1:0]  flush_tag;
  logic        flush_ready;
  logic        ras_wr_en;
  logic [2:0]  ras_wr_idx;
  logic [31:0] ras_wr_data;
  logic        ras_sp_load;
  logic [2:0]  ras_sp_value;
  logic        ras_stall;
  logic        restore_done;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  ras_ckpt_ctrl #(
    .RAS_ADDRESS(3), .XLEN(32), .CKPT_DEPTH(4), .TAG_W(2)
  ) dut (
    .CLK(CLK), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .sp_snap(sp_snap), .ras_snap(ras_snap),
    .commit_valid(commit_valid),
    .flush_valid(flush_valid), .flush_tag(flush_tag), .flush_ready(flush_ready),
    .ras_wr_en(ras_wr_en), .ras_wr_idx(ras_wr_idx), .ras_wr_data(ras_wr_data),
    .ras_sp_load(ras_sp_load), .ras_sp_value(ras_sp_value),
    .ras_stall(ras_stall), .restore_done(restore_done), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_alloc(input logic [2:0] sp, input logic [63:0] snap, input logic [1:0] exp_tag);
    alloc_valid = 1'b1;
    sp_snap     = sp;
    ras_snap    = snap;
    check_eq("alloc_ready", alloc_ready, 1'b1);
    check_eq("alloc_tag", alloc_tag, exp_tag);
    tick();
    alloc_valid = 1'b0;
    $display("alloc tag=%0d sp=%0d snap=0x%0h count=%0d", exp_tag, sp, snap, count);
  endtask

  initial begin
    reset = 1'b1; alloc_valid = 1'b0; sp_snap = '0; ras_snap = '0;
    commit_valid = 1'b0; flush_valid = 1'b0; flush_tag = '0;
    tick(); tick();
    reset = 1'b0;
    $display("reset released");
    check_eq("rst_alloc_ready", alloc_ready, 1'b1);
    check_eq("rst_flush_ready", flush_ready, 1'b1);
    check_eq("rst_count", count, 3'd0);
    check_eq("rst_stall", ras_stall, 1'b0);
    check_eq("rst_wr_en", ras_wr_en, 1'b0);
    check_eq("rst_sp_load", ras_sp_load, 1'b0);
    check_eq("rst_done", restore_done, 1'b0);
    check_eq("rst_alloc_tag", alloc_tag, 2'd0);

    // Fill all four slots.
    do_alloc(3'd1, {32'h10, 32'h11}, 2'd0);
    do_alloc(3'd2, {32'hA0, 32'hB0}, 2'd1);
    do_alloc(3'd3, {32'h30, 32'h31}, 2'd2);
    do_alloc(3'd4, {32'h40, 32'h41}, 2'd3);
    check_eq("full_count", count, 3'd4);
    check_eq("full_alloc_ready", alloc_ready, 1'b0);
    alloc_valid = 1'b1; sp_snap = 3'd6; ras_snap = {32'h60, 32'h61};
    tick();
    alloc_valid = 1'b0;
    $display("alloc attempt while full count=%0d", count);
    check_eq("full_5th_count", count, 3'd4);

    // Flush tag 1 (sp=2, hi=0xA0, lo=0xB0).
    flush_valid = 1'b1; flush_tag = 2'd1;
    check_eq("f1_flush_ready", flush_ready, 1'b1);
    tick();
    flush_valid = 1'b0;
    $display("flush tag=1 restore_lo idx=%0d data=0x%0h", ras_wr_idx, ras_wr_data);
    check_eq("f1_lo_stall", ras_stall, 1'b1);
    check_eq("f1_lo_wr_en", ras_wr_en, 1'b1);
    check_eq("f1_lo_idx", ras_wr_idx, 3'd1);
    check_eq("f1_lo_data", ras_wr_data, 32'hB0);
    check_eq("f1_lo_done", restore_done, 1'b0);
    check_eq("f1_lo_flush_ready", flush_ready, 1'b0);
    tick();
    $display("flush tag=1 restore_hi idx=%0d data=0x%0h", ras_wr_idx, ras_wr_data);
    check_eq("f1_hi_wr_en", ras_wr_en, 1'b1);
    check_eq("f1_hi_idx", ras_wr_idx, 3'd0);
    check_eq("f1_hi_data", ras_wr_data, 32'hA0);
    check_eq("f1_hi_sp_load", ras_sp_load, 1'b1);
    check_eq("f1_hi_sp_value", ras_sp_value, 3'd2);
    check_eq("f1_hi_done", restore_done, 1'b1);
    tick();
    check_eq("f1_end_stall", ras_stall, 1'b0);
    check_eq("f1_end_count", count, 3'd2);
    check_eq("f1_end_tail", alloc_tag, 2'd2);
    check_eq("f1_end_alloc_ready", alloc_ready, 1'b1);
    check_eq("f1_end_flush_ready", flush_ready, 1'b1);

    // Checkpoint with sp=0: both restore writes suppressed.
    do_alloc(3'd0, {32'h5, 32'h6}, 2'd2);
    check_eq("sp0_count", count, 3'd3);
    flush_valid = 1'b1; flush_tag = 2'd2;
    tick();
    flush_valid = 1'b0;
    $display("flush tag=2 (sp=0) restore_lo wr_en=%0d", ras_wr_en);
    check_eq("sp0_lo_stall", ras_stall, 1'b1);
    check_eq("sp0_lo_wr_en", ras_wr_en, 1'b0);
    tick();
    $display("flush tag=2 (sp=0) restore_hi wr_en=%0d", ras_wr_en);
    check_eq("sp0_hi_wr_en", ras_wr_en, 1'b0);
    check_eq("sp0_hi_sp_load", ras_sp_load, 1'b1);
    check_eq("sp0_hi_sp_value", ras_sp_value, 3'd0);
    check_eq("sp0_hi_done", restore_done, 1'b1);
    tick();
    check_eq("sp0_end_count", count, 3'd3);
    check_eq("sp0_end_tail", alloc_tag, 2'd3);

    // Fill, then commit + alloc while full: alloc refused, count drops.
    do_alloc(3'd5, {32'h50, 32'h51}, 2'd3);
    check_eq("ca_full_count", count, 3'd4);
    commit_valid = 1'b1; alloc_valid = 1'b1; sp_snap = 3'd7; ras_snap = {32'h70, 32'h71};
    check_eq("ca_alloc_ready", alloc_ready, 1'b0);
    tick();
    commit_valid = 1'b0; alloc_valid = 1'b0;
    $display("commit+alloc while full count=%0d", count);
    check_eq("ca_count", count, 3'd3);
    do_alloc(3'd7, {32'h70, 32'h71}, 2'd0);
    check_eq("ca_wrap_count", count, 3'd4);

    // Retire down to one live checkpoint (tag 0).
    commit_valid = 1'b1;
    tick(); tick(); tick();
    commit_valid = 1'b0;
    $display("three commits count=%0d", count);
    check_eq("cm3_count", count, 3'd1);

    // Flush tag 0 while the same cycle commit retires it: flush ignored.
    commit_valid = 1'b1; flush_valid = 1'b1; flush_tag = 2'd0;
    tick();
    commit_valid = 1'b0; flush_valid = 1'b0;
    $display("flush tag=0 with commit retiring it stall=%0d count=%0d", ras_stall, count);
    check_eq("fc_stall", ras_stall, 1'b0);
    check_eq("fc_count", count, 3'd0);

    // Commit on empty table: no change.
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    $display("commit on empty count=%0d", count);
    check_eq("ce_count", count, 3'd0);
    check_eq("ce_tail", alloc_tag, 2'd1);

    // Head must still be 1: tag 1 becomes the only live one and is flushable.
    do_alloc(3'd3, {32'hC0, 32'hC1}, 2'd1);
    flush_valid = 1'b1; flush_tag = 2'd1;
    tick();
    $display("flush tag=1 restore_lo idx=%0d data=0x%0h", ras_wr_idx, ras_wr_data);
    check_eq("f2_lo_stall", ras_stall, 1'b1);
    check_eq("f2_lo_wr_en", ras_wr_en, 1'b1);
    check_eq("f2_lo_idx", ras_wr_idx, 3'd2);
    check_eq("f2_lo_data", ras_wr_data, 32'hC1);
    // Flush held during RESTORE_LO is not accepted.
    check_eq("f2_lo_flush_ready", flush_ready, 1'b0);
    tick();
    flush_valid = 1'b0;
    $display("flush tag=1 restore_hi idx=%0d data=0x%0h", ras_wr_idx, ras_wr_data);
    check_eq("f2_hi_done", restore_done, 1'b1);
    check_eq("f2_hi_idx", ras_wr_idx, 3'd1);
    check_eq("f2_hi_data", ras_wr_data, 32'hC0);
    check_eq("f2_hi_sp_value", ras_sp_value, 3'd3);
    tick();
    check_eq("f2_end_stall", ras_stall, 1'b0);
    check_eq("f2_end_count", count, 3'd1);

    // Reset asserted during RESTORE_LO.
    flush_valid = 1'b1; flush_tag = 2'd1;
    tick();
    flush_valid = 1'b0;
    check_eq("rl_lo_stall", ras_stall, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset during restore_lo stall=%0d count=%0d", ras_stall, count);
    check_eq("rl_stall", ras_stall, 1'b0);
    check_eq("rl_wr_en", ras_wr_en, 1'b0);
    check_eq("rl_sp_load", ras_sp_load, 1'b0);
    check_eq("rl_done", restore_done, 1'b0);
    check_eq("rl_count", count, 3'd0);
    check_eq("rl_tail", alloc_tag, 2'd0);
    tick();
    check_eq("rl_next_wr_en", ras_wr_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_ckpt_ctrl.md
# ras_ckpt_ctrl

Checkpoint and recovery controller for the return address stack (RAS) in the out-of-order front end. It allocates one RAS checkpoint per in-flight branch at dispatch, capturing the stack pointer and the top two entries. Checkpoints retire in order at commit. On a branch mispredict it runs a short sequence that writes the saved entries back into the RAS and reloads its stack pointer, freezing normal push/pop while the sequence runs.

## Interface
Parameters:
- RAS_ADDRESS, 3, RAS index width; RAS_LEN = 2**RAS_ADDRESS
- XLEN, 32, address width
- CKPT_DEPTH, 4, number of checkpoint slots (power of two, >= 2)
- TAG_W, 2, checkpoint tag width = log2(CKPT_DEPTH)

Ports:
- CLK  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alloc_valid  in  1  dispatch requests a checkpoint
- alloc_ready  out  1  slot available and FSM in IDLE
- alloc_tag  out  TAG_W  tag granted when alloc_valid && alloc_ready
- sp_snap  in  RAS_ADDRESS  RAS stack pointer to save
- ras_snap  in  2*XLEN  {RAS[sp-2], RAS[sp-1]} to save
- commit_valid  in  1  oldest checkpoint retires
- flush_valid  in  1  mispredict; restore to checkpoint flush_tag
- flush_tag  in  TAG_W  checkpoint of the mispredicted branch
- flush_ready  out  1  flush accepted this cycle (FSM in IDLE)
- ras_wr_en  out  1  RAS restore write strobe
- ras_wr_idx  out  RAS_ADDRESS  restore write index
- ras_wr_data  out  XLEN  restore write data
- ras_sp_load  out  1  load RAS sp from ras_sp_value
- ras_sp_value  out  RAS_ADDRESS  restored sp
- ras_stall  out  1  RAS must ignore push/pop
- restore_done  out  1  one-cycle pulse, last restore cycle
- count  out  TAG_W+1  live checkpoints

## Operation
- State: a circular table of CKPT_DEPTH entries, each holding {sp, hi, lo}. Registers head (oldest), tail (next free) and count.
- alloc_ready = (state==IDLE) && (count < CKPT_DEPTH). alloc_tag = tail.
- Alloc fire (alloc_valid && alloc_ready, no accepted flush):
  - entry[tail] <= {sp_snap, ras_snap}
  - tail++ (wraps mod CKPT_DEPTH)
  - count++
- Commit (commit_valid && count>0): head++ and count-- in any FSM state. commit_valid with count==0 is ignored.
- Flush accept: flush_valid && state==IDLE. A flush is ignored otherwise; upstream holds it until flush_ready.
  - Live check: off = (flush_tag - head) mod CKPT_DEPTH, evaluated against head after any same-cycle commit. If off >= count (tag not live), the flush is ignored with no state change.
  - If live: tail <= flush_tag+1, count <= off+1. All younger checkpoints are discarded and the flushed one is kept. Latch entry[flush_tag] and go to RESTORE_LO.
- FSM IDLE -> RESTORE_LO -> RESTORE_HI -> IDLE:
  - RESTORE_LO: ras_wr_idx = sp-1, ras_wr_data = lo. ras_wr_en = (sp >= 1).
  - RESTORE_HI: ras_wr_idx = sp-2, ras_wr_data = hi. ras_wr_en = (sp >= 2). Also ras_sp_load = 1, ras_sp_value = sp, restore_done = 1.
- Index arithmetic is modulo RAS_LEN. Writes that would wrap below 0 are suppressed, but the FSM still spends the cycle.
- ras_stall = (state != IDLE).
- Simultaneous events:
  - Alloc and accepted flush in the same cycle: the flush wins and the alloc is dropped. The requester is younger, so it is squashed; the tag it saw is invalid.
  - Commit and alloc: both apply, and count is unchanged. alloc_ready uses pre-commit count.
  - Commit and flush: the commit applies first.
- All outputs are decoded from registers, except alloc_tag and alloc_ready, which have no input dependence.

## Timing
- Reset: head = tail = count = 0, state = IDLE, and every output is 0 except alloc_ready = 1 and flush_ready = 1. Table contents need no reset.
- Reset during RESTORE_* returns to IDLE on the next edge, with no further write or sp_load.
- Alloc capture uses the values present at the fire edge. The new entry is flushable from the next cycle.
- Flush accepted at edge T:
  - Cycle T+1: RESTORE_LO, ras_stall = 1.
  - Cycle T+2: RESTORE_HI, sp_load and restore_done.
  - Cycle T+3: IDLE, alloc_ready and flush_ready high again (alloc_ready only if count < CKPT_DEPTH).
- Restore latency is a fixed 2 cycles of ras_stall per flush.

## Test plan
- Reset, then 4 allocs with sp_snap = 1..4 -> tags 0,1,2,3; count = 4; alloc_ready = 0; a 5th alloc is not accepted.
- From that state, flush tag 1 (sp = 2, ras_snap = {0xA0, 0xB0}):
  - T+1: wr idx 1, data 0xB0.
  - T+2: wr idx 0, data 0xA0, sp_load = 2, restore_done = 1.
  - T+3: count = 2, tail = 2.
- Flush a checkpoint with sp = 0 -> ras_wr_en = 0 in both restore cycles; sp_load = 1 with value 0.
- Commit with count = 4 and alloc in the same cycle -> alloc not accepted; count = 3. Next cycle alloc gets tag 0 (wrap); count = 4.
- Flush of tag 0 in the same cycle as a commit that retires tag 0 -> flush ignored, no ras_stall. Commit with count = 0 -> no change.
- Flush while in RESTORE_LO -> flush_ready = 0 and the flush is ignored. Assert reset in RESTORE_LO -> next cycle IDLE, ras_wr_en = 0, count = 0.
